// File: rtl/uart_cmd_parser.sv
// Command-frame parser behind the UART receiver: validates sync/opcode (and checksum when
// UART_CMD_CHK_EN is defined), issues register-bus writes/reads and returns status/data words.
module uart_cmd_parser #(
  parameter int W_DAT = 32,
  parameter int W_ADR = 16,
  parameter int W_ACK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_DAT-1:0] rx_dat,
  input  logic             rx_fin,
  input  logic             rx_tot,
  output logic             wr_en,
  output logic             rd_en,
  output logic [W_ADR-1:0] bus_adr,
  output logic [W_DAT-1:0] wr_dat,
  input  logic [W_DAT-1:0] rd_dat,
  input  logic             rd_ack,
  output logic [W_DAT-1:0] tx_dat,
  output logic             tx_vld,
  input  logic             tx_rdy,
  output logic             busy,
  output logic [7:0]       err_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_DAT  = 3'd1,
    GET_CHK  = 3'd2,
    EXEC     = 3'd3,
    WAIT_ACK = 3'd4,
    RESP_ST  = 3'd5,
    RESP_DAT = 3'd6
  } state_t;

  localparam logic [7:0]       SYNC_RX = 8'hA5;
  localparam logic [7:0]       SYNC_TX = 8'h5A;
  localparam logic [7:0]       OP_WR   = 8'h01;
  localparam logic [7:0]       OP_RD   = 8'h02;
  localparam logic [7:0]       ST_OK   = 8'h00;
  localparam logic [7:0]       ST_OPC  = 8'h02;
  localparam logic [7:0]       ST_TMO  = 8'h05;
  localparam logic [W_ACK-1:0] ACK_MAX = '1;

  state_t             state;
  logic               is_rd;
  logic [7:0]         status;
  logic [W_DAT-1:0]   rd_buf;
  logic [W_ACK-1:0]   ack_cnt;
  logic               fin;
  logic               sync_ok;
  logic               op_wr;
  logic               op_rd;
  logic               drop_evt;
  logic               stat_evt;
`ifdef UART_CMD_CHK_EN
  localparam logic [7:0] ST_CHK = 8'h03;
  logic [W_DAT-1:0]   xor_acc;
`endif

  function automatic logic [W_DAT-1:0] resp_word(input logic [7:0] st, input logic [W_ADR-1:0] adr);
    logic [15:0] a;
    a = 16'h0000;
    a[W_ADR-1:0] = adr;
    return {SYNC_TX, st, a};
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // A timeout pulse always wins over a word-received pulse in the same cycle.
  assign fin     = rx_fin & ~rx_tot;
  assign sync_ok = (rx_dat[31:24] == SYNC_RX);
  assign op_wr   = (rx_dat[23:16] == OP_WR);
  assign op_rd   = (rx_dat[23:16] == OP_RD);

  // Error events: dropped/aborted words and nonzero response statuses.
  always_comb begin
    drop_evt = 1'b0;
    stat_evt = 1'b0;
    case (state)
      IDLE: begin
        drop_evt = fin & ~sync_ok;
        stat_evt = fin & sync_ok & ~op_wr & ~op_rd;
      end
      GET_DAT: drop_evt = rx_tot;
      GET_CHK: begin
        drop_evt = rx_tot;
`ifdef UART_CMD_CHK_EN
        stat_evt = fin & (rx_dat != xor_acc);
`endif
      end
      WAIT_ACK: begin
        drop_evt = fin;
        stat_evt = ~rd_ack & (ack_cnt == ACK_MAX);
      end
      EXEC, RESP_ST, RESP_DAT: drop_evt = fin;
      default: begin
        drop_evt = 1'b0;
        stat_evt = 1'b0;
      end
    endcase
  end

  // Saturating error counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= 8'h00;
    end else begin
      err_cnt <= sat_add(err_cnt, {1'b0, drop_evt} + {1'b0, stat_evt});
    end
  end

  // Frame FSM with registered bus strobes and response handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      is_rd   <= 1'b0;
      status  <= 8'h00;
      rd_buf  <= '0;
      ack_cnt <= '0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      bus_adr <= '0;
      wr_dat  <= '0;
      tx_dat  <= '0;
      tx_vld  <= 1'b0;
      busy    <= 1'b0;
`ifdef UART_CMD_CHK_EN
      xor_acc <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (fin && sync_ok) begin
            bus_adr <= rx_dat[W_ADR-1:0];
            is_rd   <= op_rd;
            busy    <= 1'b1;
`ifdef UART_CMD_CHK_EN
            xor_acc <= rx_dat;
`endif
            if (op_wr) begin
              state <= GET_DAT;
            end else if (op_rd) begin
`ifdef UART_CMD_CHK_EN
              state <= GET_CHK;
`else
              state <= EXEC;
              rd_en <= 1'b1;
`endif
            end else begin
              status <= ST_OPC;
              tx_dat <= resp_word(ST_OPC, rx_dat[W_ADR-1:0]);
              tx_vld <= 1'b1;
              state  <= RESP_ST;
            end
          end
        end
        GET_DAT: begin
          if (rx_tot) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rx_fin) begin
            wr_dat <= rx_dat;
`ifdef UART_CMD_CHK_EN
            xor_acc <= xor_acc ^ rx_dat;
            state   <= GET_CHK;
`else
            state <= EXEC;
            wr_en <= 1'b1;
`endif
          end
        end
        GET_CHK: begin
`ifdef UART_CMD_CHK_EN
          if (rx_tot) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rx_fin) begin
            if (rx_dat == xor_acc) begin
              state <= EXEC;
              wr_en <= ~is_rd;
              rd_en <= is_rd;
            end else begin
              status <= ST_CHK;
              tx_dat <= resp_word(ST_CHK, bus_adr);
              tx_vld <= 1'b1;
              state  <= RESP_ST;
            end
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        EXEC: begin
          ack_cnt <= '0;
          if (is_rd) begin
            state <= WAIT_ACK;
          end else begin
            status <= ST_OK;
            tx_dat <= resp_word(ST_OK, bus_adr);
            tx_vld <= 1'b1;
            state  <= RESP_ST;
          end
        end
        WAIT_ACK: begin
          // An ack arriving on the limit cycle still counts as an ack.
          if (rd_ack) begin
            rd_buf <= rd_dat;
            status <= ST_OK;
            tx_dat <= resp_word(ST_OK, bus_adr);
            tx_vld <= 1'b1;
            state  <= RESP_ST;
          end else if (ack_cnt == ACK_MAX) begin
            status <= ST_TMO;
            tx_dat <= resp_word(ST_TMO, bus_adr);
            tx_vld <= 1'b1;
            state  <= RESP_ST;
          end else begin
            ack_cnt <= ack_cnt + W_ACK'(1);
          end
        end
        RESP_ST: begin
          if (tx_rdy) begin
            if (is_rd && (status == ST_OK)) begin
              tx_dat <= rd_buf;
              state  <= RESP_DAT;
            end else begin
              tx_vld <= 1'b0;
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        RESP_DAT: begin
          if (tx_rdy) begin
            tx_vld <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          tx_vld <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser (W_ACK=4); adapts frames to UART_CMD_CHK_EN when defined.
module tb_uart_cmd_parser;

  localparam int W_DAT = 32;
  localparam int W_ADR = 16;
  localparam int W_ACK = 4;
`ifdef UART_CMD_CHK_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W_DAT-1:0] rx_dat;
  logic             rx_fin;
  logic             rx_tot;
  logic             wr_en;
  logic             rd_en;
  logic [W_ADR-1:0] bus_adr;
  logic [W_DAT-1:0] wr_dat;
  logic [W_DAT-1:0] rd_dat;
  logic             rd_ack;
  logic [W_DAT-1:0] tx_dat;
  logic             tx_vld;
  logic             tx_rdy;
  logic             busy;
  logic [7:0]       err_cnt;

  uart_cmd_parser #(.W_DAT(W_DAT), .W_ADR(W_ADR), .W_ACK(W_ACK)) dut (
    .clk(clk), .rst_n(rst_n), .rx_dat(rx_dat), .rx_fin(rx_fin), .rx_tot(rx_tot),
    .wr_en(wr_en), .rd_en(rd_en), .bus_adr(bus_adr), .wr_dat(wr_dat),
    .rd_dat(rd_dat), .rd_ack(rd_ack), .tx_dat(tx_dat), .tx_vld(tx_vld),
    .tx_rdy(tx_rdy), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                n;
    logic [2:0][31:0]  w;
    int                ack_dly;
    logic [31:0]       rdd;
    int                nwr;
    int                nrd;
    logic [15:0]       adr;
    logic [31:0]       wdat;
    int                nresp;
    logic [31:0]       r0;
    logic [31:0]       r1;
    int                err;
    int                lat_lo;
    int                lat_hi;
  } vec_t;

  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_err = 8'h00;

  function automatic vec_t mk(int n, logic [31:0] w0, logic [31:0] w1, logic [31:0] w2,
                              int ack_dly, logic [31:0] rdd, int nwr, int nrd,
                              logic [15:0] adr, logic [31:0] wdat, int nresp,
                              logic [31:0] r0, logic [31:0] r1, int err, int lo, int hi);
    vec_t v;
    v.n = n; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.ack_dly = ack_dly; v.rdd = rdd;
    v.nwr = nwr; v.nrd = nrd; v.adr = adr; v.wdat = wdat; v.nresp = nresp;
    v.r0 = r0; v.r1 = r1; v.err = err; v.lat_lo = lo; v.lat_hi = hi;
    return v;
  endfunction

  function automatic logic [7:0] sat_inc(logic [7:0] a, int d);
    int s;
    s = int'(a) + d;
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    rx_dat = w;
    rx_fin = 1'b1;
    tick();
    rx_fin = 1'b0;
  endtask

  task automatic wait_rd_en(input string name);
    int seen;
    seen = 0;
    for (int c = 0; c < 6 && seen == 0; c++) begin
      if (rd_en) seen = 1;
      else tick();
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  // Cycle 0 is the first cycle after the edge accepting the final frame word.
  task automatic run_vec(input vec_t v, input int idx);
    int nwr, nrd, nresp, first_vld, ack_cd;
    logic [31:0] resp0, resp1, wdat_seen;
    logic [15:0] adr_seen;
    nwr = 0; nrd = 0; nresp = 0; first_vld = -1; ack_cd = 0;
    resp0 = '0; resp1 = '0; wdat_seen = '0; adr_seen = '0;
    tx_rdy = 1'b1;
    for (int k = 0; k < v.n; k++) send_word(v.w[k]);
    for (int c = 0; c < 30; c++) begin
      rd_ack = 1'b0;
      if (wr_en) begin nwr++; adr_seen = bus_adr; wdat_seen = wr_dat; end
      if (rd_en) begin
        nrd++; adr_seen = bus_adr; ack_cd = v.ack_dly;
      end else if (ack_cd > 0) begin
        ack_cd--;
        if (ack_cd == 0) begin rd_ack = 1'b1; rd_dat = v.rdd; end
      end
      if (tx_vld) begin
        if (first_vld < 0) first_vld = c;
        if (nresp == 0) resp0 = tx_dat;
        else if (nresp == 1) resp1 = tx_dat;
        nresp++;
      end
      tick();
    end
    rd_ack = 1'b0;
    exp_err = sat_inc(exp_err, v.err);
    chk($sformatf("v%0d_nwr", idx), 32'(nwr), 32'(v.nwr));
    chk($sformatf("v%0d_nrd", idx), 32'(nrd), 32'(v.nrd));
    if (v.nwr + v.nrd > 0) chk($sformatf("v%0d_adr", idx), {16'h0, adr_seen}, {16'h0, v.adr});
    if (v.nwr > 0) chk($sformatf("v%0d_wdat", idx), wdat_seen, v.wdat);
    chk($sformatf("v%0d_nresp", idx), 32'(nresp), 32'(v.nresp));
    if (v.nresp > 0) begin
      chk($sformatf("v%0d_resp0", idx), resp0, v.r0);
      chk_rng($sformatf("v%0d_lat", idx), first_vld, v.lat_lo, v.lat_hi);
    end
    if (v.nresp > 1) chk($sformatf("v%0d_resp1", idx), resp1, v.r1);
    chk($sformatf("v%0d_err", idx), {24'h0, err_cnt}, {24'h0, exp_err});
    chk($sformatf("v%0d_busy", idx), {31'h0, busy}, 32'h0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_wr_en"}, {31'h0, wr_en}, 32'h0);
    chk({name, "_rd_en"}, {31'h0, rd_en}, 32'h0);
    chk({name, "_bus_adr"}, {16'h0, bus_adr}, 32'h0);
    chk({name, "_wr_dat"}, wr_dat, 32'h0);
    chk({name, "_tx_dat"}, tx_dat, 32'h0);
    chk({name, "_tx_vld"}, {31'h0, tx_vld}, 32'h0);
    chk({name, "_busy"}, {31'h0, busy}, 32'h0);
    chk({name, "_err_cnt"}, {24'h0, err_cnt}, 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nvld;
    logic [31:0] held;
    rst_n = 1'b0; rx_dat = '0; rx_fin = 1'b0; rx_tot = 1'b0;
    rd_dat = '0; rd_ack = 1'b0; tx_rdy = 1'b1;

    // n, w0, w1, w2, ack_dly, rdd, nwr, nrd, adr, wdat, nresp, r0, r1, err, lat_lo, lat_hi
    vecs.push_back(mk(2 + CK, 32'hA5010012, 32'hDEADBEEF, 32'h7BACBEFD, 0, 32'h0,
                      1, 0, 16'h0012, 32'hDEADBEEF, 1, 32'h5A000012, 32'h0, 0, 1, 1));
    vecs.push_back(mk(1 + CK, 32'hA5020034, 32'hA5020034, 32'h0, 3, 32'h12345678,
                      0, 1, 16'h0034, 32'h0, 2, 32'h5A000034, 32'h12345678, 0, 4, 4));
    vecs.push_back(mk(1, 32'h11223344, 32'h0, 32'h0, 0, 32'h0,
                      0, 0, 16'h0, 32'h0, 0, 32'h0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(2 + CK, 32'hA50100AB, 32'hCAFEF00D, 32'h6FFFF0A6, 0, 32'h0,
                      1, 0, 16'h00AB, 32'hCAFEF00D, 1, 32'h5A0000AB, 32'h0, 0, 1, 1));
    vecs.push_back(mk(1, 32'hA5070034, 32'h0, 32'h0, 0, 32'h0,
                      0, 0, 16'h0, 32'h0, 1, 32'h5A020034, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1 + CK, 32'hA5020056, 32'hA5020056, 32'h0, 0, 32'h0,
                      0, 1, 16'h0056, 32'h0, 1, 32'h5A050056, 32'h0, 1, 15, 17));
    vecs.push_back(mk(1 + CK, 32'hA5020078, 32'hA5020078, 32'h0, 1, 32'hA1B2C3D4,
                      0, 1, 16'h0078, 32'h0, 2, 32'h5A000078, 32'hA1B2C3D4, 0, 2, 2));
    vecs.push_back(mk(2 + CK, 32'hA501FFFF, 32'h00000001, 32'hA501FFFE, 0, 32'h0,
                      1, 0, 16'hFFFF, 32'h00000001, 1, 32'h5A00FFFF, 32'h0, 0, 1, 1));
`ifdef UART_CMD_CHK_EN
    vecs.push_back(mk(3, 32'hA5010012, 32'hDEADBEEF, 32'h00000000, 0, 32'h0,
                      0, 0, 16'h0, 32'h0, 1, 32'h5A030012, 32'h0, 1, 0, 0));
`endif

    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_all_zero("reset");

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Backpressure on a read response, with an overrun word during RESP_ST.
    tx_rdy = 1'b0;
    send_word(32'hA5020034);
    if (CK == 1) send_word(32'hA5020034);
    wait_rd_en("bp_rd_en");
    tick(); tick();
    rd_dat = 32'h12345678; rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0; rd_dat = '0;
    chk("bp_vld", {31'h0, tx_vld}, 32'h1);
    chk("bp_resp0", tx_dat, 32'h5A000034);
    held = tx_dat;
    nvld = 0;
    for (int c = 0; c < 5; c++) begin
      if (tx_vld && tx_dat == held) nvld++;
      rx_dat = 32'hFFFFFFFF;
      rx_fin = (c == 2) ? 1'b1 : 1'b0;
      tick();
      rx_fin = 1'b0;
    end
    exp_err = sat_inc(exp_err, 1);
    chk("bp_stable", 32'(nvld), 32'd5);
    chk("bp_hold_dat", tx_dat, 32'h5A000034);
    chk("ovr_err", {24'h0, err_cnt}, {24'h0, exp_err});
    tx_rdy = 1'b1;
    tick();
    chk("bp_resp1", tx_dat, 32'h12345678);
    chk("bp_resp1_vld", {31'h0, tx_vld}, 32'h1);
    tick();
    chk("bp_done_vld", {31'h0, tx_vld}, 32'h0);
    chk("bp_done_busy", {31'h0, busy}, 32'h0);

    // rx_tot (with a simultaneous rx_fin) after a write header aborts silently.
    send_word(32'hA5010012);
    rx_dat = 32'h00000000; rx_tot = 1'b1; rx_fin = 1'b1;
    tick();
    rx_tot = 1'b0; rx_fin = 1'b0;
    nvld = 0;
    for (int c = 0; c < 10; c++) begin
      if (tx_vld || wr_en) nvld++;
      tick();
    end
    exp_err = sat_inc(exp_err, 1);
    chk("tot_quiet", 32'(nvld), 32'd0);
    chk("tot_busy", {31'h0, busy}, 32'h0);
    chk("tot_err", {24'h0, err_cnt}, {24'h0, exp_err});

    // rx_tot in IDLE is ignored, and masks a bad-sync rx_fin in the same cycle.
    rx_dat = 32'h11223344; rx_tot = 1'b1; rx_fin = 1'b1;
    tick();
    rx_tot = 1'b0; rx_fin = 1'b0;
    tick();
    chk("idle_tot_err", {24'h0, err_cnt}, {24'h0, exp_err});
    chk("idle_tot_busy", {31'h0, busy}, 32'h0);

    // 300 bad-sync words saturate the error counter.
    rx_dat = 32'h11223344; rx_fin = 1'b1;
    for (int c = 0; c < 300; c++) tick();
    rx_fin = 1'b0;
    tick();
    chk("sat_err", {24'h0, err_cnt}, 32'h000000FF);

    // Reset while waiting for a read ack clears every output on the next edge.
    send_word(32'hA5020034);
    if (CK == 1) send_word(32'hA5020034);
    wait_rd_en("rst_rd_en");
    tick(); tick();
    chk("rst_pre_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    tick();
    chk_all_zero("midrst");
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
